gf_addsub_issuer: RTL and testbench
===================================

// Module: gf_addsub_issuer
// PURPOSE
//  Initiator/collector for the GF(p) modular add/sub unit (2-cycle fixed latency, en->valid, no stall).
//  Accepts operand pairs on a valid/ready stream and issues them to the adder.
//  Tags each result in flight, absorbs results in a credit-guarded FIFO and returns them on a
//  valid/ready stream with backpressure. Sits between the controller's op queue and the shared adder.
// PARAMETERS
//  BW_GF       `BW_GF  operand/result width (field element bits)
//  FIFO_DEPTH  4       result FIFO entries; also the max issued-but-unread ops (power of 2, >=2)
//  TAG_W       4       opaque tag width carried from input to output
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        synchronous active-low reset
//  in_valid    in   1        operand pair valid
//  in_ready    out  1        issuer can accept
//  in_a        in   BW_GF    operand a, must be < `PRIME
//  in_b        in   BW_GF    operand b, must be < `PRIME
//  in_sub      in   1        1: a-b mod p, 0: a+b mod p
//  in_tag      in   TAG_W    caller tag
//  add_en      out  1        issue strobe to adder
//  add_a       out  BW_GF    adder operand a
//  add_b       out  BW_GF    adder operand b
//  add_is_sub  out  1        adder mode
//  add_out     in   BW_GF    adder result
//  add_valid   in   1        adder result valid (2 cycles after add_en)
//  out_valid   out  1        result available
//  out_ready   in   1        consumer accepts
//  out_data    out  BW_GF    canonical result in [0, p-1]
//  out_tag     out  TAG_W    tag of out_data
//  proto_err   out  1        sticky: add_valid without a matching issue 2 cycles earlier, or vice versa
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FIFO empty, credits=FIFO_DEPTH, tag pipe cleared; in_ready=0,
//    add_en=0, add_a/add_b/add_is_sub=0, out_valid=0, out_data=0, out_tag=0, proto_err=0.
//    Reset mid-operation drops all in-flight and buffered results; late add_valid ignored 2 cycles.
//  - Credits: credits = FIFO_DEPTH - fifo_count - inflight. in_ready = (credits != 0) && !proto_err.
//  - Issue: in_valid && in_ready at edge N -> add_en=1 with registered operands/mode during cycle N+1.
//    One issue per cycle max; back-to-back issue allowed.
//  - Tag pipe: 2-stage shift {vld,tag} registered alongside add_en; stage-2 vld must equal add_valid.
//    Mismatch sets proto_err (sticky until reset); result still written if add_valid=1 and space exists.
//  - Capture: add_valid=1 -> push {canon(add_out), tag} into FIFO same edge.
//    canon: add_out == `PRIME -> 0, else add_out (adder may return p for a zero result).
//  - Output: out_valid = !fifo_empty; out_data/out_tag = head, registered, stable while out_valid && !out_ready.
//    Pop on out_valid && out_ready. Issue-to-out_valid latency = 4 cycles (reg, adder 2, FIFO write).
//  - Simultaneous push and pop on a full FIFO: legal, count unchanged. Push on full (only via
//    proto_err path): dropped, proto_err=1. Pointers wrap modulo FIFO_DEPTH.
//  - Simultaneous issue and pop: credit -1 +1 -> unchanged. Results always in issue order.
//  - Widths: operands passed unmodified; no arithmetic on the BW_GF path other than == `PRIME compare.
// CONFIGURATION
//  GF_ADDSUB_RANGE_CHECK_EN defined: in_a or in_b >= `PRIME on an accepted op -> operands replaced
//    by 0 before issue, out_tag unchanged, extra output range_err (1 bit, sticky, reset 0) set.
//  Not defined: no check, no range_err port; out-of-range operands pass to the adder as-is.
// TESTING
//  1 add: p=`PRIME, a=5,b=7,sub=0,tag=3, out_ready=1 -> out_data=12, out_tag=3 exactly 4 cycles after accept.
//  2 sub wrap: a=3,b=10,sub=1 -> out_data=p-7; a=b=9,sub=1 -> out_data=0 (canon of p), proto_err=0.
//  3 backpressure: out_ready=0, stream 6 ops -> exactly FIFO_DEPTH(4) accepted, in_ready=0;
//    release out_ready -> 4 results in order, tags 0..3, then remaining 2 accepted.
//  4 burst: back-to-back 16 ops, out_ready=1 -> one result per cycle, in order, no drops.
//  5 errors: inject add_valid with no issue -> proto_err=1, in_ready=0; rst_n=0 one cycle mid-burst
//    -> all outputs at reset values, stale add_valid ignored; with GF_ADDSUB_RANGE_CHECK_EN, a=p -> range_err=1.

Source files
------------

// File: rtl/gf_addsub_issuer.sv
// gf_addsub_issuer: issues GF(p) add/sub ops to a 2-cycle adder, collects tagged results in a FIFO.
// Optional GF_ADDSUB_RANGE_CHECK_EN: zero out-of-range operands and raise sticky range_err.

`ifndef BW_GF
`define BW_GF 16
`endif
`ifndef PRIME
`define PRIME 65521
`endif

module gf_addsub_issuer #(
    parameter int BW_GF      = `BW_GF,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW_GF-1:0] in_a,
    input  logic [BW_GF-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             add_en,
    output logic [BW_GF-1:0] add_a,
    output logic [BW_GF-1:0] add_b,
    output logic             add_is_sub,
    input  logic [BW_GF-1:0] add_out,
    input  logic             add_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW_GF-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             proto_err
`ifdef GF_ADDSUB_RANGE_CHECK_EN
    ,
    output logic             range_err
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int UW = PW + 3;
    localparam logic [BW_GF-1:0] PRIME_V = BW_GF'(`PRIME);
    localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [UW-1:0]    DEPTH_U = UW'(FIFO_DEPTH);

    logic             add_en_q, add_en_d;
    logic [BW_GF-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_sub_q, add_sub_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [BW_GF-1:0] mem_q [FIFO_DEPTH];
    logic [BW_GF-1:0] mem_d [FIFO_DEPTH];
    logic [TAG_W-1:0] tmem_q [FIFO_DEPTH];
    logic [TAG_W-1:0] tmem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [BW_GF-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             proto_err_q, proto_err_d;
    logic [1:0]       ign_q, ign_d;
    logic [UW-1:0]    used;
    logic             pop, accept, live, cap, full, push;
    logic [BW_GF-1:0] op_a, op_b, res;
`ifdef GF_ADDSUB_RANGE_CHECK_EN
    logic             range_err_q, range_err_d;
    logic             oor;
`endif

    always_comb begin
        pop = out_valid_q && out_ready;
        // slots promised: buffered + in flight, a same-cycle pop frees one
        used = UW'(cnt_q) + UW'(add_en_q) + UW'(s1_vld_q)
             + UW'(s2_vld_q) - UW'(pop);
        in_ready = rst_n && !proto_err_q && (used < DEPTH_U);
        accept = in_valid && in_ready;
        op_a = in_a;
        op_b = in_b;
`ifdef GF_ADDSUB_RANGE_CHECK_EN
        oor = (in_a >= PRIME_V) || (in_b >= PRIME_V);
        range_err_d = range_err_q || (accept && oor);
        if (oor) begin
            op_a = '0;
            op_b = '0;
        end
`endif
        add_en_d  = accept;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        tag_d     = tag_q;
        if (accept) begin
            add_a_d   = op_a;
            add_b_d   = op_b;
            add_sub_d = in_sub;
            tag_d     = in_tag;
        end
        s1_vld_d = add_en_q;
        s1_tag_d = tag_q;
        s2_vld_d = s1_vld_q;
        s2_tag_d = s1_tag_q;

        // adder results that belonged to ops issued before reset are ignored
        live = (ign_q == 2'd0);
        cap  = live && add_valid;
        full = (cnt_q == DEPTH_C);
        push = cap && (!full || pop);
        proto_err_d = proto_err_q || (live && (s2_vld_q != add_valid))
                    || (cap && full && !pop);
        res = (add_out == PRIME_V) ? '0 : add_out;

        mem_d  = mem_q;
        tmem_d = tmem_q;
        if (push) begin
            mem_d[wr_ptr_q]  = res;
            tmem_d[wr_ptr_q] = s2_tag_q;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        out_valid_d = (cnt_d != '0);
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (out_valid_d) begin
            out_data_d = mem_d[rd_ptr_d];
            out_tag_d  = tmem_d[rd_ptr_d];
        end
        ign_d = (ign_q != 2'd0) ? ign_q - 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_en_q    <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_sub_q   <= 1'b0;
            tag_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_tag_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            proto_err_q <= 1'b0;
            ign_q       <= 2'd2;
        end else begin
            add_en_q    <= add_en_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_sub_q   <= add_sub_d;
            tag_q       <= tag_d;
            s1_vld_q    <= s1_vld_d;
            s1_tag_q    <= s1_tag_d;
            s2_vld_q    <= s2_vld_d;
            s2_tag_q    <= s2_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            proto_err_q <= proto_err_d;
            ign_q       <= ign_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        tmem_q <= tmem_d;
    end

`ifdef GF_ADDSUB_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) range_err_q <= 1'b0;
        else        range_err_q <= range_err_d;
    end
    assign range_err = range_err_q;
`endif

    assign add_en     = add_en_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_is_sub = add_sub_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_tag    = out_tag_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_gf_addsub_issuer.sv
// tb_gf_addsub_issuer: randomized bench with a 2-cycle adder model and an in-order result queue.

`ifndef BW_GF
`define BW_GF 16
`endif
`ifndef PRIME
`define PRIME 65521
`endif

module tb_gf_addsub_issuer;

    localparam int     BW = `BW_GF;
    localparam int     TW = 4;
    localparam longint P  = `PRIME;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          in_sub = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          add_en;
    logic [BW-1:0] add_a, add_b;
    logic          add_is_sub;
    logic [BW-1:0] add_out;
    logic          add_valid;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          proto_err;
`ifdef GF_ADDSUB_RANGE_CHECK_EN
    logic          range_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] q_d[$];
    logic [TW-1:0] q_t[$];

    always #5 clk = ~clk;

    gf_addsub_issuer #(.BW_GF(BW), .FIFO_DEPTH(4), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_is_sub(add_is_sub),
        .add_out(add_out), .add_valid(add_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .proto_err(proto_err)
`ifdef GF_ADDSUB_RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    // Field arithmetic reference: canonical (a op b) mod p.
    function automatic logic [BW-1:0] gf(input logic [BW-1:0] a,
                                         input logic [BW-1:0] b,
                                         input logic s);
        longint r;
        r = s ? (longint'(a) - longint'(b) + P) % P
              : (longint'(a) + longint'(b)) % P;
        return BW'(r);
    endfunction

    // Adder model: 2-cycle latency, returns p instead of 0, not reset.
    logic          st1_v = 1'b0, st2_v = 1'b0, inj = 1'b0;
    logic [BW-1:0] st1_r = '0, st2_r = '0;
    always @(posedge clk) begin
        st1_v <= add_en;
        st1_r <= (gf(add_a, add_b, add_is_sub) == '0) ? BW'(P)
               : gf(add_a, add_b, add_is_sub);
        st2_v <= st1_v;
        st2_r <= st1_r;
    end
    assign add_valid = st2_v | inj;
    assign add_out   = st2_r;

    task automatic go_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op(input logic [TW-1:0] t);
        in_a   = BW'($urandom_range(32'(P - 1)));
        in_b   = BW'($urandom_range(32'(P - 1)));
        in_sub = 1'($urandom_range(1));
        in_tag = t;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        go_edge;
        go_edge;
        checks++;
        if ({in_ready, add_en, add_a, add_b, add_is_sub, out_valid,
             out_data, out_tag, proto_err} !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%b en=%b a=%h b=%h ov=%b d=%h t=%h pe=%b exp all 0",
                     in_ready, add_en, add_a, add_b, out_valid, out_data, out_tag, proto_err);
        end
        rst_n = 1'b1;
        go_edge;
        go_edge;
        go_edge;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", in_ready);
        end
    endtask

    task automatic test_add;
        int cyc;
        logic [BW-1:0] gd;
        logic [TW-1:0] gt;
        cyc = 0;
        gd = '0;
        gt = '0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = BW'(5);
        in_b = BW'(7);
        in_sub = 1'b0;
        in_tag = TW'(3);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_accept ready=%b exp 1", in_ready);
        end
        go_edge;
        in_valid = 1'b0;
        checks++;
        if ({add_en, add_a, add_b, add_is_sub} !== {1'b1, BW'(5), BW'(7), 1'b0}) begin
            errors++;
            $display("FAIL add_issue en=%b a=%0d b=%0d sub=%b exp 1 5 7 0",
                     add_en, add_a, add_b, add_is_sub);
        end
        // cycle 1 is the add_en cycle right after the accepting edge
        for (int k = 1; k <= 8; k++) begin
            if (out_valid && cyc == 0) begin
                cyc = k;
                gd = out_data;
                gt = out_tag;
            end
            go_edge;
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL add_latency cycle=%0d exp 4", cyc);
        end
        checks++;
        if (gd !== BW'(12) || gt !== TW'(3)) begin
            errors++;
            $display("FAIL add_result data=%0d tag=%0d exp 12 3", gd, gt);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_popped out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_sub_wrap;
        logic [BW-1:0] ed [2];
        int n;
        ed[0] = BW'(P - 7);
        ed[1] = '0;
        n = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = BW'(3);
        in_b = BW'(10);
        in_sub = 1'b1;
        in_tag = TW'(1);
        go_edge;
        in_a = BW'(9);
        in_b = BW'(9);
        in_tag = TW'(2);
        go_edge;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid && n < 2) begin
                checks++;
                if (out_data !== ed[n] || out_tag !== TW'(n + 1)) begin
                    errors++;
                    $display("FAIL sub_wrap%0d data=%0d tag=%0d exp %0d %0d",
                             n, out_data, out_tag, ed[n], n + 1);
                end
                n++;
            end
            go_edge;
        end
        checks++;
        if (n != 2 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL sub_count results=%0d pe=%b exp 2 0", n, proto_err);
        end
    endtask

    task automatic test_backpressure;
        int idx, pops;
        idx = 0;
        pops = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rand_op(TW'(idx));
            #1;
            if (in_valid && in_ready) begin
                q_d.push_back(gf(in_a, in_b, in_sub));
                q_t.push_back(in_tag);
                idx++;
            end
            go_edge;
        end
        checks++;
        if (idx != 4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit accepted=%0d ready=%b exp 4 0", idx, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== q_d[0] || out_tag !== q_t[0]) begin
            errors++;
            $display("FAIL bp_head_hold ov=%b data=%h tag=%h exp 1 %h %h",
                     out_valid, out_data, out_tag, q_d[0], q_t[0]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = (idx < 6);
            rand_op(TW'(idx));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_d.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra data=%h tag=%h exp none", out_data, out_tag);
                end else begin
                    if (out_data !== q_d[0] || out_tag !== q_t[0]) begin
                        errors++;
                        $display("FAIL bp_order data=%h tag=%0d exp %h %0d",
                                 out_data, out_tag, q_d[0], q_t[0]);
                    end
                    q_d.delete(0);
                    q_t.delete(0);
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                q_d.push_back(gf(in_a, in_b, in_sub));
                q_t.push_back(in_tag);
                idx++;
            end
            go_edge;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 6 || pops != 6) begin
            errors++;
            $display("FAIL bp_total accepted=%0d popped=%0d exp 6 6", idx, pops);
        end
    endtask

    task automatic test_back_to_back;
        int stalls, pops, first, last;
        stalls = 0;
        pops = 0;
        first = -1;
        last = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = (k < 16);
            rand_op(TW'(k));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_d.size() == 0 || out_data !== q_d[0] || out_tag !== q_t[0]) begin
                    errors++;
                    $display("FAIL b2b_order data=%h tag=%0d left=%0d",
                             out_data, out_tag, q_d.size());
                end
                if (q_d.size() != 0) begin
                    q_d.delete(0);
                    q_t.delete(0);
                end
                if (first < 0) first = k;
                last = k;
                pops++;
            end
            if (in_valid) begin
                if (in_ready) begin
                    q_d.push_back(gf(in_a, in_b, in_sub));
                    q_t.push_back(in_tag);
                end else begin
                    stalls++;
                end
            end
            go_edge;
        end
        in_valid = 1'b0;
        checks++;
        if (stalls != 0 || pops != 16 || last - first != 15) begin
            errors++;
            $display("FAIL b2b_rate stalls=%0d pops=%0d span=%0d exp 0 16 15",
                     stalls, pops, last - first);
        end
    endtask

    task automatic test_random;
        int acc;
        acc = 0;
        for (int k = 0; k < 340; k++) begin
            in_valid = (k < 300) && ($urandom_range(9) < 7);
            out_ready = (k >= 300) || ($urandom_range(9) < 6);
            rand_op(TW'($urandom_range(15)));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_d.size() == 0 || out_data !== q_d[0] || out_tag !== q_t[0]) begin
                    errors++;
                    $display("FAIL rand_order data=%h tag=%0d left=%0d",
                             out_data, out_tag, q_d.size());
                end
                if (q_d.size() != 0) begin
                    q_d.delete(0);
                    q_t.delete(0);
                end
            end
            if (in_valid && in_ready) begin
                q_d.push_back(gf(in_a, in_b, in_sub));
                q_t.push_back(in_tag);
                acc++;
            end
            go_edge;
        end
        in_valid = 1'b0;
        checks++;
        if (q_d.size() != 0 || acc == 0 || proto_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain left=%0d accepted=%0d pe=%b ov=%b exp 0 >0 0 0",
                     q_d.size(), acc, proto_err, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        int n;
        bad = 1'b0;
        n = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_op(TW'(k));
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_d.size() == 0 || out_data !== q_d[0] || out_tag !== q_t[0]) begin
                    errors++;
                    $display("FAIL mid_order data=%h tag=%0d", out_data, out_tag);
                end
                if (q_d.size() != 0) begin
                    q_d.delete(0);
                    q_t.delete(0);
                end
            end
            if (in_ready) begin
                q_d.push_back(gf(in_a, in_b, in_sub));
                q_t.push_back(in_tag);
            end
            go_edge;
        end
        rst_n = 1'b0;
        #1;
        go_edge;
        checks++;
        if ({in_ready, add_en, add_a, add_b, add_is_sub, out_valid,
             out_data, out_tag, proto_err} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state rdy=%b en=%b ov=%b d=%h t=%h pe=%b exp all 0",
                     in_ready, add_en, out_valid, out_data, out_tag, proto_err);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        q_d.delete();
        q_t.delete();
        for (int k = 0; k < 6; k++) begin
            if (out_valid || proto_err) bad = 1'b1;
            go_edge;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale_ignored saw_output_or_err=%b exp 0", bad);
        end
        in_valid = 1'b1;
        in_a = BW'(P - 1);
        in_b = BW'(2);
        in_sub = 1'b0;
        in_tag = TW'(11);
        go_edge;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid && n == 0) begin
                n = 1;
                checks++;
                if (out_data !== BW'(1) || out_tag !== TW'(11)) begin
                    errors++;
                    $display("FAIL mid_resume data=%0d tag=%0d exp 1 11", out_data, out_tag);
                end
            end
            go_edge;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL mid_resume_timeout results=%0d exp 1", n);
        end
    endtask

    task automatic test_proto_err;
        out_ready = 1'b0;
        in_valid = 1'b0;
        inj = 1'b1;
        go_edge;
        inj = 1'b0;
        in_valid = 1'b1;
        rand_op(TW'(5));
        #1;
        checks++;
        if (proto_err !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL proto_inject pe=%b ready=%b exp 1 0", proto_err, in_ready);
        end
        go_edge;
        go_edge;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky pe=%b exp 1", proto_err);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        go_edge;
        rst_n = 1'b1;
        go_edge;
        go_edge;
        go_edge;
        checks++;
        if (proto_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL proto_clear pe=%b ov=%b ready=%b exp 0 0 1",
                     proto_err, out_valid, in_ready);
        end
    endtask

`ifdef GF_ADDSUB_RANGE_CHECK_EN
    task automatic test_range;
        int n;
        n = 0;
        out_ready = 1'b1;
        checks++;
        if (range_err !== 1'b0) begin
            errors++;
            $display("FAIL range_init got %b exp 0", range_err);
        end
        in_valid = 1'b1;
        in_a = BW'(P);
        in_b = BW'(4);
        in_sub = 1'b0;
        in_tag = TW'(9);
        go_edge;
        in_valid = 1'b0;
        checks++;
        if (range_err !== 1'b1 || add_a !== '0 || add_b !== '0) begin
            errors++;
            $display("FAIL range_flag err=%b a=%h b=%h exp 1 0 0", range_err, add_a, add_b);
        end
        for (int k = 0; k < 8; k++) begin
            if (out_valid && n == 0) begin
                n = 1;
                checks++;
                if (out_data !== '0 || out_tag !== TW'(9)) begin
                    errors++;
                    $display("FAIL range_result data=%0d tag=%0d exp 0 9", out_data, out_tag);
                end
            end
            go_edge;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL range_timeout results=%0d exp 1", n);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_add;
        test_sub_wrap;
        test_backpressure;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_proto_err;
`ifdef GF_ADDSUB_RANGE_CHECK_EN
        test_range;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
